// File: rtl/placement_pkg.sv
// Shared constants and FSM encoding for the strip placement controller.
package placement_pkg;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int NUM_STRIPS  = 13;
  localparam int NUM_GROUPS  = 5;
  localparam int CAP_DEFAULT = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EVAL,
    ST_WR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/strip_placer_if.sv
// Request/response handshake between a requester and the strip placer.
interface strip_placer_if;

  logic                              req_valid;
  logic                              req_ready;
  logic [placement_pkg::DATA_W-1:0]  req_size;
  logic                              resp_valid;
  logic                              resp_ready;
  logic [placement_pkg::ADDR_W-1:0]  resp_strip;
  logic                              resp_fail;

  modport master (
    output req_valid, req_size, resp_ready,
    input  req_ready, resp_valid, resp_strip, resp_fail
  );

  modport slave (
    input  req_valid, req_size, resp_ready,
    output req_ready, resp_valid, resp_strip, resp_fail
  );

endinterface

// File: rtl/strip_min3.sv
// Combinational best-fit over three lanes: lowest occupancy that still fits, lowest lane on ties.
module strip_min3 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] occ [3],
  input  logic [ADDR_WIDTH-1:0] addr [3],
  input  logic [2:0]            lane_valid,
  input  logic [DATA_WIDTH-1:0] size,
  input  logic [DATA_WIDTH:0]   cap,
  output logic                  found,
  output logic [DATA_WIDTH-1:0] best_occ,
  output logic [ADDR_WIDTH-1:0] best_addr
);

  // Lanes are in ascending address order, so strict < keeps the lowest address on a tie.
  always_comb begin
    found     = 1'b0;
    best_occ  = '1;
    best_addr = '0;
    for (int i = 0; i < 3; i++) begin
      if (lane_valid[i] &&
          (({1'b0, occ[i]} + {1'b0, size}) <= cap) &&
          (!found || (occ[i] < best_occ))) begin
        found     = 1'b1;
        best_occ  = occ[i];
        best_addr = addr[i];
      end
    end
  end

endmodule

// File: rtl/strip_ram.sv
// 3-read/1-write strip occupancy RAM with registered read data; write wins over read.
module strip_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr_write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_read1,
  input  logic [ADDR_WIDTH-1:0] addr_read2,
  input  logic [ADDR_WIDTH-1:0] addr_read3,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] data_out3
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Contents survive reset; a write is blocked while reset is held.
  always_ff @(posedge clk) begin
    if (write_en && !rst) begin
      mem[addr_write] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out1 <= '0;
      data_out2 <= '0;
      data_out3 <= '0;
    end else if (read_en && !write_en) begin
      data_out1 <= mem[addr_read1];
      data_out2 <= mem[addr_read2];
      data_out3 <= mem[addr_read3];
    end
  end

endmodule

// File: rtl/strip_placer.sv
// Best-fit placement controller: scans strips three at a time, then writes back the chosen strip.
module strip_placer #(
  parameter int ADDR_WIDTH = placement_pkg::ADDR_W,
  parameter int DATA_WIDTH = placement_pkg::DATA_W,
  parameter int NUM_STRIPS = placement_pkg::NUM_STRIPS,
  parameter int CAP        = placement_pkg::CAP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  strip_placer_if.slave         bus,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_wr,
  output logic [DATA_WIDTH-1:0] ram_data_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr_rd1,
  output logic [ADDR_WIDTH-1:0] ram_addr_rd2,
  output logic [ADDR_WIDTH-1:0] ram_addr_rd3,
  input  logic [DATA_WIDTH-1:0] ram_data_rd1,
  input  logic [DATA_WIDTH-1:0] ram_data_rd2,
  input  logic [DATA_WIDTH-1:0] ram_data_rd3
);

  import placement_pkg::*;

  localparam int LAST_GROUP = (NUM_STRIPS + 2) / 3 - 1;

  state_t                state;
  logic [2:0]            group;
  logic [DATA_WIDTH-1:0] size_q;
  logic [DATA_WIDTH-1:0] best_occ;
  logic [ADDR_WIDTH-1:0] best_strip;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_fail_q;
  logic [ADDR_WIDTH-1:0] resp_strip_q;

  logic [DATA_WIDTH-1:0] lane_occ [3];
  logic [ADDR_WIDTH-1:0] eval_addr [3];
  logic [2:0]            lane_valid;
  logic                  size_ok;
  logic                  found;
  logic [DATA_WIDTH-1:0] min_occ;
  logic [ADDR_WIDTH-1:0] min_addr;
  logic                  take;
  logic [DATA_WIDTH-1:0] next_best_occ;
  logic [ADDR_WIDTH-1:0] next_best_strip;

  // Lanes past the last strip map to the sentinel address 0, which also marks them invalid.
  function automatic logic [ADDR_WIDTH-1:0] lane_addr(input logic [2:0] g, input int lane);
    int a;
    a = 3 * int'(g) + 1 + lane;
    return (a <= NUM_STRIPS) ? ADDR_WIDTH'(a) : '0;
  endfunction

  assign lane_occ[0] = ram_data_rd1;
  assign lane_occ[1] = ram_data_rd2;
  assign lane_occ[2] = ram_data_rd3;

  assign size_ok = (size_q != '0) && (int'(size_q) <= CAP);

  always_comb begin
    lane_valid = '0;
    for (int i = 0; i < 3; i++) begin
      eval_addr[i]  = lane_addr(group, i);
      lane_valid[i] = (eval_addr[i] != '0) && size_ok;
    end
  end

  strip_min3 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_min3 (
    .occ        (lane_occ),
    .addr       (eval_addr),
    .lane_valid (lane_valid),
    .size       (size_q),
    .cap        ((DATA_WIDTH + 1)'(CAP)),
    .found      (found),
    .best_occ   (min_occ),
    .best_addr  (min_addr)
  );

  assign take            = found && (min_occ < best_occ);
  assign next_best_occ   = take ? min_occ  : best_occ;
  assign next_best_strip = take ? min_addr : best_strip;

  // RESP spends one cycle publishing so the write-back has landed in the RAM before
  // resp_valid rises; this also fixes the latency at 12 edges regardless of outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      group        <= '0;
      size_q       <= '0;
      best_occ     <= '1;
      best_strip   <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fail_q  <= 1'b0;
      resp_strip_q <= '0;
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      ram_addr_wr  <= '0;
      ram_data_wr  <= '0;
      ram_addr_rd1 <= '0;
      ram_addr_rd2 <= '0;
      ram_addr_rd3 <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            size_q       <= bus.req_size;
            group        <= '0;
            best_occ     <= '1;
            best_strip   <= '0;
            req_ready_q  <= 1'b0;
            ram_read_en  <= 1'b1;
            ram_addr_rd1 <= lane_addr(3'd0, 0);
            ram_addr_rd2 <= lane_addr(3'd0, 1);
            ram_addr_rd3 <= lane_addr(3'd0, 2);
            state        <= ST_RD;
          end
        end
        ST_RD: begin
          ram_read_en  <= 1'b0;
          ram_addr_rd1 <= '0;
          ram_addr_rd2 <= '0;
          ram_addr_rd3 <= '0;
          state        <= ST_EVAL;
        end
        ST_EVAL: begin
          best_occ   <= next_best_occ;
          best_strip <= next_best_strip;
          if (group == 3'(LAST_GROUP)) begin
            if (next_best_strip != '0) begin
              ram_write_en <= 1'b1;
              ram_addr_wr  <= next_best_strip;
              ram_data_wr  <= next_best_occ + size_q;
            end
            state <= ST_WR;
          end else begin
            group        <= group + 3'd1;
            ram_read_en  <= 1'b1;
            ram_addr_rd1 <= lane_addr(group + 3'd1, 0);
            ram_addr_rd2 <= lane_addr(group + 3'd1, 1);
            ram_addr_rd3 <= lane_addr(group + 3'd1, 2);
            state        <= ST_RD;
          end
        end
        ST_WR: begin
          ram_write_en <= 1'b0;
          ram_addr_wr  <= '0;
          ram_data_wr  <= '0;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
            resp_strip_q <= best_strip;
            resp_fail_q  <= (best_strip == '0);
          end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_strip_q <= '0;
            resp_fail_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_strip = resp_strip_q;
  assign bus.resp_fail  = resp_fail_q;

endmodule

// File: tb/tb_strip_placer.sv
// Directed bench: strip_placer driving a real strip_ram, checked with immediate assertions.
module tb_strip_placer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  strip_placer_if bus_if();

  logic       dut_we, dut_re;
  logic [3:0] dut_waddr, rd_a1, rd_a2, rd_a3;
  logic [7:0] dut_wdata, rd_d1, rd_d2, rd_d3;

  logic       pre_we   = 1'b0;
  logic [3:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  logic       ram_we;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;

  int checks    = 0;
  int errors    = 0;
  int wr_count  = 0;
  int bus_viol  = 0;

  always #5 clk = ~clk;

  // Preload shares the RAM write port; the placer is idle whenever the bench uses it.
  assign ram_we    = pre_we | dut_we;
  assign ram_waddr = pre_we ? pre_addr : dut_waddr;
  assign ram_wdata = pre_we ? pre_data : dut_wdata;

  strip_placer u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .ram_write_en (dut_we),
    .ram_read_en  (dut_re),
    .ram_addr_wr  (dut_waddr),
    .ram_data_wr  (dut_wdata),
    .ram_addr_rd1 (rd_a1),
    .ram_addr_rd2 (rd_a2),
    .ram_addr_rd3 (rd_a3),
    .ram_data_rd1 (rd_d1),
    .ram_data_rd2 (rd_d2),
    .ram_data_rd3 (rd_d3)
  );

  strip_ram u_ram (
    .clk        (clk),
    .rst        (rst),
    .write_en   (ram_we),
    .read_en    (dut_re),
    .addr_write (ram_waddr),
    .data_in    (ram_wdata),
    .addr_read1 (rd_a1),
    .addr_read2 (rd_a2),
    .addr_read3 (rd_a3),
    .data_out1  (rd_d1),
    .data_out2  (rd_d2),
    .data_out3  (rd_d3)
  );

  always @(negedge clk) begin
    if (dut_we === 1'b1) begin
      wr_count++;
      if (dut_re !== 1'b0 || dut_waddr == 4'd0 || dut_waddr > 4'd13) bus_viol++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input int d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 4'(a);
    pre_data = 8'(d);
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic fill(input int d);
    for (int a = 0; a < 16; a++) preload(a, d);
  endtask

  task automatic apply_stimulus(input int size, output logic [3:0] strip, output logic fail,
                                output int lat);
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_size  = 8'(size);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    lat = 0;
    while (bus_if.resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    strip = bus_if.resp_strip;
    fail  = bus_if.resp_fail;
    @(negedge clk);
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic run_request(input string tag, input int size, input int exp_strip,
                             input int exp_fail);
    logic [3:0] strip;
    logic       fail;
    int         lat;
    int         w0;
    w0 = wr_count;
    apply_stimulus(size, strip, fail, lat);
    check_output($sformatf("%s_latency", tag), lat, 12);
    check_output($sformatf("%s_strip", tag), strip, exp_strip);
    check_output($sformatf("%s_fail", tag), fail, exp_fail);
    check_output($sformatf("%s_writes", tag), wr_count - w0, exp_fail ? 0 : 1);
  endtask

  initial begin
    logic [3:0] strip;
    logic       fail;
    int         lat;
    int         w0;
    int         bad;

    bus_if.req_valid  = 1'b0;
    bus_if.req_size   = '0;
    bus_if.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_req_ready", bus_if.req_ready, 1);
    check_output("reset_resp_valid", bus_if.resp_valid, 0);
    check_output("reset_resp_strip", bus_if.resp_strip, 0);
    check_output("reset_read_en", dut_re, 0);
    check_output("reset_write_en", dut_we, 0);
    @(negedge clk);
    rst = 1'b0;

    // Empty RAM: first strip takes the request.
    fill(0);
    run_request("empty", 10, 1, 0);
    check_output("empty_mem1", u_ram.mem[1], 10);

    fill(50);
    preload(7, 20);
    run_request("lowocc", 30, 7, 0);
    check_output("lowocc_mem7", u_ram.mem[7], 50);

    // 100+29 overflows CAP by one; 100+28 lands exactly on CAP.
    fill(100);
    run_request("cap_plus1", 29, 0, 1);
    run_request("tie_first", 28, 1, 0);
    check_output("tie_first_mem1", u_ram.mem[1], 128);
    run_request("tie_second", 28, 2, 0);
    check_output("tie_second_mem2", u_ram.mem[2], 128);

    fill(120);
    run_request("full_9", 9, 0, 1);
    run_request("size_zero", 0, 0, 1);
    run_request("size_200", 200, 0, 1);
    run_request("full_8", 8, 1, 0);
    check_output("full_8_mem1", u_ram.mem[1], 128);

    // Masked lanes 14/15 and sentinel 0 hold zero occupancy and must never win.
    fill(90);
    preload(0, 0);
    preload(13, 0);
    preload(14, 0);
    preload(15, 0);
    run_request("last_strip", 5, 13, 0);
    check_output("last_strip_mem13", u_ram.mem[13], 5);
    run_request("masked_lanes", 5, 13, 0);
    check_output("masked_lanes_mem13", u_ram.mem[13], 10);
    check_output("masked_mem14", u_ram.mem[14], 0);
    check_output("masked_mem15", u_ram.mem[15], 0);
    check_output("sentinel_mem0", u_ram.mem[0], 0);

    // Reset in the EVAL cycle of group 2 (fifth edge after accept).
    fill(50);
    w0 = wr_count;
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_size  = 8'd10;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("midrst_req_ready", bus_if.req_ready, 1);
    check_output("midrst_resp_valid", bus_if.resp_valid, 0);
    check_output("midrst_read_en", dut_re, 0);
    check_output("midrst_write_en", dut_we, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int a = 1; a <= 13; a++) if (u_ram.mem[a] !== 8'd50) bad++;
    check_output("midrst_ram_intact", bad, 0);
    check_output("midrst_writes", wr_count - w0, 0);
    run_request("after_rst", 10, 1, 0);
    check_output("after_rst_mem1", u_ram.mem[1], 60);

    // Response held while resp_ready stays low; a new request is not accepted.
    fill(40);
    w0 = wr_count;
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_size  = 8'd7;
    @(posedge clk);
    #1;
    lat = 0;
    while (bus_if.resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output("hold_latency", lat, 12);
    repeat (5) @(posedge clk);
    #1;
    check_output("hold_resp_valid", bus_if.resp_valid, 1);
    check_output("hold_resp_strip", bus_if.resp_strip, 1);
    check_output("hold_resp_fail", bus_if.resp_fail, 0);
    check_output("hold_req_ready", bus_if.req_ready, 0);
    @(negedge clk);
    bus_if.req_valid  = 1'b0;
    bus_if.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.resp_ready = 1'b0;
    check_output("release_req_ready", bus_if.req_ready, 1);
    check_output("release_resp_valid", bus_if.resp_valid, 0);
    repeat (15) @(posedge clk);
    #1;
    check_output("hold_mem1", u_ram.mem[1], 47);
    check_output("hold_writes", wr_count - w0, 1);

    check_output("bus_rules", bus_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
